pfb_mac_drain: RTL
==================

// Module: pfb_mac_drain
// PURPOSE
// Output end of the PFB DSP48 MAC cascade: tracks sample validity and phase through the fixed
// MAC pipeline latency. Rounds and saturates the 48-bit accumulator tap (mac_p) to OUT_WIDTH.
// Buffers results in a credit-controlled FIFO and presents them as AXI-stream.
// Drives the cascade's shared clock enable (mac_ce), so downstream backpressure freezes the MAC
// chain instead of dropping samples.
// PARAMETERS
// PIPE_LAT     6   ce-qualified cycles from accepted s_valid to valid mac_p at cascade end
// SHIFT        24  bit index of output LSB within mac_p (1..47)
// OUT_WIDTH    16  signed output width
// PHASE_WIDTH  6   phase tag width carried alongside each sample
// FIFO_DEPTH   16  output FIFO entries; must be >= PIPE_LAT+1 (elaboration error otherwise)
// PORTS
// clk            in   1            clock
// sync_reset     in   1            synchronous reset, active high
// s_valid        in   1            sample presented to MAC chain this cycle
// s_phase        in   PHASE_WIDTH  phase index of presented sample
// s_ready        out  1            equals mac_ce; sample accepted when s_valid & s_ready
// mac_ce         out  1            clock enable to every MAC in the cascade
// mac_p          in   48           P output of last MAC in cascade
// m_axis_tvalid  out  1            output sample valid
// m_axis_tdata   out  OUT_WIDTH    rounded/saturated sample, two's complement
// m_axis_tuser   out  PHASE_WIDTH  phase tag of output sample
// m_axis_tready  in   1            downstream ready
// sat_flag       out  1            sticky: some output saturated since reset
// BEHAVIOUR
// - Reset: mac_ce/s_ready=0, m_axis_tvalid=0, tdata/tuser=0, sat_flag=0.
//   Tag pipe, inflight counter and FIFO are cleared. mac_ce returns high the first cycle after
//   reset deasserts. Stale mac_p values are never emitted.
// - Tag pipe: vld_sr/phase_sr, PIPE_LAT deep. Shifts only when mac_ce=1; stage0 <= s_valid,
//   s_phase.
// - Capture: wr = mac_ce & vld_sr[PIPE_LAT-1]. On wr, the FIFO is written with
//   {phase_sr tail, rnd_sat(mac_p)}. When mac_ce=0, mac_p holds and nothing is written
//   (no duplicates).
// - Credits: inflight +1 on s_valid&mac_ce, -1 on wr (both in one cycle: unchanged).
//   mac_ce = (fifo_count + inflight) < FIFO_DEPTH, computed from registered counts only.
//   A same-cycle FIFO read is credited the next cycle. The FIFO can never overflow.
// - rnd_sat: t = mac_p + 2^(SHIFT-1), computed at 49 bits signed (round half toward +inf).
//   Then q = t >>> SHIFT.
//   If q > 2^(OUT_WIDTH-1)-1, output max positive and set sat_flag.
//   If q < -2^(OUT_WIDTH-1), output max negative and set sat_flag.
//   Otherwise output q[OUT_WIDTH-1:0].
// - FIFO: first-word-fall-through; tvalid = !empty; pop on tvalid&tready.
//   Write and read in the same cycle are allowed, including when full (read frees a slot).
//   Order is strictly preserved.
// - Latency (tready=1, no stall): sample accepted in cycle 0 appears on m_axis in cycle
//   PIPE_LAT+1. Sustained throughput is 1 sample/clk.
// - Upstream must hold s_valid/s_phase while s_ready=0.
// TESTING
// 1 Single sample, phase 3, mac_p=48'h0000_0012_3480_0000 -> tdata 16'h1235, tuser 3,
//   tvalid in cycle 7 after accept; sat_flag stays 0.
// 2 mac_p=48'h7FFF_FFFF_FFFF -> 16'h7FFF, sat_flag=1.
//   Then mac_p=48'h8000_0000_0000 -> 16'h8000; sat_flag remains 1.
// 3 mac_p=48'hFFFF_FF80_0000 (-0.5 LSB) -> 16'h0000.
//   mac_p=48'hFFFF_FF7F_FFFF -> 16'hFFFF.
// 4 tready=0 with continuous s_valid -> exactly 16 samples accepted, then s_ready=0 and mac_ce=0.
//   Raise tready -> 16 outputs in order with correct phases, no loss, no duplicates, and input
//   resumes.
// 5 sync_reset pulse with 5 samples in flight and 3 in FIFO -> next cycle tvalid=0 and
//   sat_flag=0. No stale outputs after release. First new sample emerges PIPE_LAT+1 cycles
//   after its accept.
// 6 100 back-to-back samples, tready=1 -> 100 outputs on consecutive cycles, s_ready never low,
//   phases 0..63 wrap correctly.

Source files
------------

// File: rtl/pfb_mac_drain.sv
// pfb_mac_drain: tracks MAC cascade validity/phase, rounds+saturates mac_p, credit-controlled FWFT FIFO to AXI-stream
module pfb_mac_drain #(
    parameter int PIPE_LAT    = 6,
    parameter int SHIFT       = 24,
    parameter int OUT_WIDTH   = 16,
    parameter int PHASE_WIDTH = 6,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_sync_reset,
    input  logic                   i_s_valid,
    input  logic [PHASE_WIDTH-1:0] i_s_phase,
    output logic                   o_s_ready,
    output logic                   o_mac_ce,
    input  logic [47:0]            i_mac_p,
    output logic                   o_m_axis_tvalid,
    output logic [OUT_WIDTH-1:0]   o_m_axis_tdata,
    output logic [PHASE_WIDTH-1:0] o_m_axis_tuser,
    input  logic                   i_m_axis_tready,
    output logic                   o_sat_flag
);
    localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = PHASE_WIDTH + OUT_WIDTH;
    localparam logic signed [48:0] MAXQ = (49'sd1 <<< (OUT_WIDTH - 1)) - 49'sd1;
    localparam logic signed [48:0] MINQ = -(49'sd1 <<< (OUT_WIDTH - 1));
    localparam logic signed [48:0] HALF = 49'sd1 <<< (SHIFT - 1);

    if (FIFO_DEPTH < PIPE_LAT + 1) begin : g_depth_check
        $error("FIFO_DEPTH must be >= PIPE_LAT+1");
    end

    logic [PIPE_LAT-1:0]    r_vld;
    logic [PHASE_WIDTH-1:0] r_ph [PIPE_LAT];
    logic [CW-1:0]          r_infl, r_cnt;
    logic [AW-1:0]          r_wp, r_rp;
    logic [EW-1:0]          r_mem [FIFO_DEPTH];
    logic                   r_sat;
    logic                   w_ce, w_acc, w_wr, w_rd, w_vld, w_hi, w_lo;
    logic signed [48:0]     w_q;
    logic [OUT_WIDTH-1:0]   w_d;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_ce  = !i_sync_reset && (({1'b0, r_cnt} + {1'b0, r_infl}) < (CW + 1)'(FIFO_DEPTH));
        w_acc = i_s_valid && w_ce;
        w_wr  = w_ce && r_vld[PIPE_LAT-1];
        w_vld = r_cnt != '0;
        w_rd  = w_vld && i_m_axis_tready;
        w_q   = ($signed({i_mac_p[47], i_mac_p}) + HALF) >>> SHIFT;
        w_hi  = w_q > MAXQ;
        w_lo  = w_q < MINQ;
        w_d   = w_hi ? {1'b0, {(OUT_WIDTH - 1){1'b1}}} :
                w_lo ? {1'b1, {(OUT_WIDTH - 1){1'b0}}} : w_q[OUT_WIDTH-1:0];
        o_mac_ce        = w_ce;
        o_s_ready       = w_ce;
        o_m_axis_tvalid = w_vld;
        {o_m_axis_tuser, o_m_axis_tdata} = w_vld ? r_mem[r_rp] : '0;
        o_sat_flag      = r_sat;
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_reset) begin
            r_vld  <= '0;
            r_infl <= '0;
            r_cnt  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_sat  <= 1'b0;
        end else begin
            if (w_ce) r_vld <= PIPE_LAT'({r_vld, i_s_valid});
            r_infl <= r_infl + CW'(w_acc) - CW'(w_wr);
            r_cnt  <= r_cnt + CW'(w_wr) - CW'(w_rd);
            if (w_wr) r_wp <= nxt(r_wp);
            if (w_rd) r_rp <= nxt(r_rp);
            r_sat  <= r_sat || (w_wr && (w_hi || w_lo));
        end
    end

    // w_ce is forced low during reset, so neither the phase pipe nor the FIFO array needs clearing
    always_ff @(posedge i_clk) begin
        if (w_ce) begin
            r_ph[0] <= i_s_phase;
            for (int i = 1; i < PIPE_LAT; i++) r_ph[i] <= r_ph[i-1];
        end
        if (w_wr) r_mem[r_wp] <= {r_ph[PIPE_LAT-1], w_d};
    end
endmodule
